// File: rtl/nv_ram_fifo_ctrl_80x14.sv
// Valid/ready FIFO controller wrapped around the 80x14 two-port RAM. The RAM's
// two-cycle registered read is hidden behind a stallable two-stage prefetch pipeline.
module nv_ram_fifo_ctrl_80x14 #(
  parameter int DEPTH = 80,
  parameter int AW    = 7,
  parameter int DW    = 14
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_req_pvld,
  output logic          wr_req_prdy,
  input  logic [DW-1:0] wr_req_pd,
  output logic          rd_req_pvld,
  input  logic          rd_req_prdy,
  output logic [DW-1:0] rd_req_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  output logic          ram_ore,
  input  logic [DW-1:0] ram_dout,
  output logic [AW-1:0] fifo_count,
  output logic          fifo_idle
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL = AW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_fetch_ptr_q, rd_fetch_ptr_d;
  logic [AW-1:0] count_q, count_d;
  logic [AW-1:0] unfetched_q, unfetched_d;
  logic          s1_vld_q, s1_vld_d;
  logic          s2_vld_q, s2_vld_d;
  logic          push, pop, s1_adv, s2_adv;

  // Admission uses only the registered count; a same-cycle pop never frees a slot early.
  assign wr_req_prdy = (count_q < FULL);
  assign push        = wr_req_pvld & wr_req_prdy;
  assign pop         = s2_vld_q & rd_req_prdy;

  assign s2_adv  = !s2_vld_q | rd_req_prdy;
  assign ram_ore = s1_vld_q & s2_adv;
  assign s1_adv  = !s1_vld_q | ram_ore;
  assign ram_re  = (unfetched_q != '0) & s1_adv;

  assign ram_we      = push;
  assign ram_wa      = wr_ptr_q;
  assign ram_di      = wr_req_pd;
  assign ram_ra      = rd_fetch_ptr_q;
  assign rd_req_pvld = s2_vld_q;
  assign rd_req_pd   = ram_dout;
  assign fifo_count  = count_q;
  assign fifo_idle   = (count_q == '0) & !push;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_fetch_ptr_d = rd_fetch_ptr_q;
    count_d        = count_q;
    unfetched_d    = unfetched_q;
    s1_vld_d       = s1_vld_q;
    s2_vld_d       = s2_vld_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (ram_re) begin
      rd_fetch_ptr_d = (rd_fetch_ptr_q == LAST) ? '0 : rd_fetch_ptr_q + 1'b1;
    end

    // Occupancy covers entries still in flight in s1/s2, which protects them from overwrite.
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    if (push && !ram_re) begin
      unfetched_d = unfetched_q + 1'b1;
    end else if (!push && ram_re) begin
      unfetched_d = unfetched_q - 1'b1;
    end

    if (ram_re) begin
      s1_vld_d = 1'b1;
    end else if (ram_ore) begin
      s1_vld_d = 1'b0;
    end

    if (ram_ore) begin
      s2_vld_d = 1'b1;
    end else if (rd_req_prdy) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q       <= '0;
      rd_fetch_ptr_q <= '0;
      count_q        <= '0;
      unfetched_q    <= '0;
      s1_vld_q       <= 1'b0;
      s2_vld_q       <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_fetch_ptr_q <= rd_fetch_ptr_d;
      count_q        <= count_d;
      unfetched_q    <= unfetched_d;
      s1_vld_q       <= s1_vld_d;
      s2_vld_q       <= s2_vld_d;
    end
  end
endmodule
